// File: rtl/jof32_pkg.sv
// jof32_pkg: shared widths, stage states and the MEM/WB bundle type for the JOF32 pipeline
package jof32_pkg;
    localparam int DATA_W = 32;
    localparam int REG_ADDR_W = 4;
    typedef enum logic {IDLE, WAIT} state_e;
    typedef struct packed {
        logic [DATA_W-1:0] result_mem;
        logic [DATA_W-1:0] result_alu;
        logic sel_wb;
        logic reg_wr;
        logic [REG_ADDR_W-1:0] dir_wb;
        logic valid;
    } mem_wb_t;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; a bubble clears the whole bundle
module mem_wb_reg
    import jof32_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    bubble_i,
    input  mem_wb_t d_i,
    output mem_wb_t q_o
);
    always_ff @(posedge clk) begin
        if (rst || bubble_i) q_o <= '0;
        else q_o <= d_i;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: JOF32 memory stage with req/ack data-memory handshake and timeout.
// MEM_ALIGN_CHECK_EN rejects misaligned memops in IDLE with a mem_err pulse.
module mem_access_stage
    import jof32_pkg::*;
#(
    parameter int DATA_W = jof32_pkg::DATA_W,
    parameter int REG_ADDR_W = jof32_pkg::REG_ADDR_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_W-1:0]     result_alu_in,
    input  logic [DATA_W-1:0]     store_data_in,
    input  logic                  mem_rd_in,
    input  logic                  mem_wr_in,
    input  logic                  sel_wb_in,
    input  logic                  reg_wr_in,
    input  logic [REG_ADDR_W-1:0] dir_wb_in,
    output logic                  stall_out,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  valid_out,
    output logic [DATA_W-1:0]     result_mem,
    output logic [DATA_W-1:0]     result_alu,
    output logic                  sel_wb,
    output logic                  reg_wr_out,
    output logic [REG_ADDR_W-1:0] dir_wb_out,
    output logic                  mem_err
);
    state_e st_q, st_d;
    logic req_q, req_d, we_q, we_d, sel_q, sel_d, rw_q, rw_d, err_q, err_d, bubble;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] dir_q, dir_d;
    logic [15:0] cnt_q, cnt_d;
    mem_wb_t wb_d, wb_q;
    logic memop, misal, timeout;

    assign memop = valid_in & (mem_rd_in | mem_wr_in);
`ifdef MEM_ALIGN_CHECK_EN
    assign misal = result_alu_in[1:0] != 2'b00;
`else
    assign misal = 1'b0;
`endif
    assign timeout = cnt_q == 16'(TIMEOUT_CYCLES - 1);

    always_comb begin
        st_d = st_q;
        req_d = req_q;
        we_d = we_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        sel_d = sel_q;
        rw_d = rw_q;
        dir_d = dir_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        bubble = 1'b0;
        stall_out = 1'b0;
        wb_d = '0;
        if (st_q == IDLE) begin
            if (memop && !misal) begin
                stall_out = 1'b1;
                st_d = WAIT;
                req_d = 1'b1;
                we_d = mem_wr_in & ~mem_rd_in;
                addr_d = result_alu_in;
                wdata_d = store_data_in;
                sel_d = sel_wb_in;
                rw_d = reg_wr_in;
                dir_d = dir_wb_in;
                cnt_d = '0;
                bubble = 1'b1;
            end else begin
                // a misaligned memop lands here too: retired as a non-writing error
                wb_d = '{result_mem: '0, result_alu: result_alu_in, sel_wb: sel_wb_in,
                         reg_wr: reg_wr_in & valid_in & ~memop, dir_wb: dir_wb_in, valid: valid_in};
                err_d = memop;
            end
        end else if (dmem_ack) begin
            wb_d = '{result_mem: we_q ? '0 : dmem_rdata, result_alu: addr_q, sel_wb: sel_q,
                     reg_wr: rw_q, dir_wb: dir_q, valid: 1'b1};
            req_d = 1'b0;
            st_d = IDLE;
        end else if (timeout) begin
            wb_d = '{result_mem: '0, result_alu: addr_q, sel_wb: sel_q,
                     reg_wr: 1'b0, dir_wb: dir_q, valid: 1'b1};
            err_d = 1'b1;
            req_d = 1'b0;
            st_d = IDLE;
        end else begin
            stall_out = 1'b1;
            cnt_d = cnt_q + 16'd1;
            bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= IDLE;
            req_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            sel_q <= 1'b0;
            rw_q <= 1'b0;
            dir_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            st_q <= st_d;
            req_q <= req_d;
            we_q <= we_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            sel_q <= sel_d;
            rw_q <= rw_d;
            dir_q <= dir_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk     (clk),
        .rst     (rst),
        .bubble_i(bubble),
        .d_i     (wb_d),
        .q_o     (wb_q)
    );

    assign dmem_req = req_q;
    assign dmem_we = we_q;
    assign dmem_addr = addr_q;
    assign dmem_wdata = wdata_q;
    assign valid_out = wb_q.valid;
    assign result_mem = wb_q.result_mem;
    assign result_alu = wb_q.result_alu;
    assign sel_wb = wb_q.sel_wb;
    assign reg_wr_out = wb_q.reg_wr & wb_q.valid;
    assign dir_wb_out = wb_q.dir_wb;
    assign mem_err = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage (TIMEOUT_CYCLES=4)
module tb_mem_access_stage;
    logic clk = 1'b0, rst = 1'b1;
    logic valid_in = 0, mem_rd_in = 0, mem_wr_in = 0, sel_wb_in = 0, reg_wr_in = 0, dmem_ack = 0;
    logic [31:0] result_alu_in = 0, store_data_in = 0, dmem_rdata = 0;
    logic [3:0] dir_wb_in = 0;
    logic stall_out, dmem_req, dmem_we, valid_out, sel_wb, reg_wr_out, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, result_mem, result_alu;
    logic [3:0] dir_wb_out;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .result_alu_in(result_alu_in),
        .store_data_in(store_data_in), .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
        .sel_wb_in(sel_wb_in), .reg_wr_in(reg_wr_in), .dir_wb_in(dir_wb_in),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .valid_out(valid_out), .result_mem(result_mem), .result_alu(result_alu),
        .sel_wb(sel_wb), .reg_wr_out(reg_wr_out), .dir_wb_out(dir_wb_out), .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] sd, input logic rw, input logic [3:0] dir, input logic s);
        valid_in = v; mem_rd_in = rd; mem_wr_in = wr; result_alu_in = a;
        store_data_in = sd; reg_wr_in = rw; dir_wb_in = dir; sel_wb_in = s;
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        #2;
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_rmem", result_mem, 0);
        chk("rst_ralu", result_alu, 0);
        chk("rst_sel", sel_wb, 0);
        chk("rst_regwr", reg_wr_out, 0);
        chk("rst_dir", dir_wb_out, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_stall", stall_out, 0);

        drive(1, 0, 0, 32'h1234, 0, 1, 4'd5, 1);
        #2 chk("alu_stall", stall_out, 0);
        tick();
        chk("alu_valid", valid_out, 1);
        chk("alu_ralu", result_alu, 32'h1234);
        chk("alu_dir", dir_wb_out, 5);
        chk("alu_regwr", reg_wr_out, 1);
        chk("alu_sel", sel_wb, 1);
        chk("alu_rmem", result_mem, 0);
        chk("alu_req", dmem_req, 0);

        drive(1, 1, 0, 32'h100, 32'h0, 1, 4'd3, 0);
        for (int c = 0; c < 4; c++) begin
            dmem_ack = (c == 3);
            dmem_rdata = (c == 3) ? 32'hDEADBEEF : 32'h11111111;
            #2 chk("ld_stall", stall_out, (c < 3) ? 1 : 0);
            if (c >= 1) begin
                chk("ld_req", dmem_req, 1);
                chk("ld_addr", dmem_addr, 32'h100);
                chk("ld_we", dmem_we, 0);
                chk("ld_bubble", valid_out, 0);
            end
            tick();
        end
        dmem_ack = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ld_valid", valid_out, 1);
        chk("ld_rmem", result_mem, 32'hDEADBEEF);
        chk("ld_ralu", result_alu, 32'h100);
        chk("ld_regwr", reg_wr_out, 1);
        chk("ld_dir", dir_wb_out, 3);
        chk("ld_req_drop", dmem_req, 0);
        chk("ld_err", mem_err, 0);

        drive(1, 0, 1, 32'h200, 32'hCAFEF00D, 0, 4'd7, 0);
        #2 chk("st_stall0", stall_out, 1);
        tick();
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_wdata", dmem_wdata, 32'hCAFEF00D);
        chk("st_addr", dmem_addr, 32'h200);
        dmem_ack = 1;
        #2 chk("st_stall1", stall_out, 0);
        tick();
        dmem_ack = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("st_valid", valid_out, 1);
        chk("st_regwr", reg_wr_out, 0);
        chk("st_rmem", result_mem, 0);
        chk("st_ralu", result_alu, 32'h200);

        drive(1, 1, 0, 32'h300, 0, 1, 4'd2, 0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            #2 chk("to_stall", stall_out, (c < 4) ? 1 : 0);
            chk("to_req", dmem_req, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("to_err", mem_err, 1);
        chk("to_valid", valid_out, 1);
        chk("to_regwr", reg_wr_out, 0);
        chk("to_req_drop", dmem_req, 0);
        dmem_ack = 1;
        dmem_rdata = 32'h77777777;
        #2 chk("late_stall", stall_out, 0);
        tick();
        dmem_ack = 0;
        chk("late_err", mem_err, 0);
        chk("late_valid", valid_out, 0);
        chk("late_req", dmem_req, 0);

        drive(1, 1, 0, 32'h400, 0, 1, 4'd4, 0);
        tick();
        chk("rw_req", dmem_req, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("rw_req_drop", dmem_req, 0);
        chk("rw_valid", valid_out, 0);
        drive(1, 0, 0, 32'h55, 0, 1, 4'd9, 0);
        #2 chk("rw_alu_stall", stall_out, 0);
        tick();
        chk("rw_alu_valid", valid_out, 1);
        chk("rw_alu_ralu", result_alu, 32'h55);
        chk("rw_alu_dir", dir_wb_out, 9);

        drive(1, 1, 0, 32'h102, 0, 1, 4'd6, 0);
`ifdef MEM_ALIGN_CHECK_EN
        #2 chk("al_stall", stall_out, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("al_req", dmem_req, 0);
        chk("al_err", mem_err, 1);
        chk("al_valid", valid_out, 1);
        chk("al_regwr", reg_wr_out, 0);
`else
        #2 chk("na_stall", stall_out, 1);
        tick();
        chk("na_req", dmem_req, 1);
        chk("na_addr", dmem_addr, 32'h102);
        dmem_ack = 1;
        dmem_rdata = 32'h0BADF00D;
        tick();
        dmem_ack = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("na_rmem", result_mem, 32'h0BADF00D);
        chk("na_err", mem_err, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
